// File: rtl/rtc_bus_if.sv
// Multiplexed address/data RTC bus: master drives ADin and the active-low strobes,
// responder returns ADout qualified by ad_oe.
interface rtc_bus_if;
    logic [7:0] ADin;
    logic       ad;
    logic       cs;
    logic       wr;
    logic       rd;
    logic [7:0] ADout;
    logic       ad_oe;

    modport master (output ADin, ad, cs, wr, rd, input ADout, ad_oe);
    modport slave  (input ADin, ad, cs, wr, rd, output ADout, ad_oe);
endinterface

// File: rtl/rtc_bus_responder.sv
// Responder end of the RTC bus: address/data phase decode, BCD register file and timekeeping.
// Define TICK_GEN_EN to derive the 1 Hz tick internally from CLK_HZ instead of tick_1hz.
module rtc_bus_responder #(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter logic [7:0]  IDLE_DATA = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    rtc_bus_if.slave   bus,
    output logic [7:0] addr_q
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;

    state_t     state_q, state_d;
    logic       ad_s_q, cs_s_q, wr_s_q, rd_s_q, wr_p_q;
    logic [7:0] adin_s_q;
    logic [7:0] addr_d;
    logic [7:0] adout_q, adout_d;
    logic       ad_oe_q, ad_oe_d;
    logic       pend_q, pend_d;
    logic [7:0] ctrl_q, sec_q, min_q, hour_q, date_q, month_q, year_q, wday_q;
    logic [7:0] ctrl_d, sec_d, min_d, hour_d, date_d, month_d, year_d, wday_d;
    logic [8:0] sec_st_s, min_st_s, hour_st_s, date_st_s, month_st_s, year_st_s, wday_st_s;
    logic       tick_s, wr_rise_s, reading_s, do_tick_s, wr_en_s;
    logic       inc_min_s, inc_hour_s, inc_date_s, inc_month_s, inc_year_s;
    logic [7:0] rd_mux_s;
    logic       unused_carry_s;

    // Returns {carry, next}; any value at or past max_v (including illegal digits) wraps.
    function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] max_v,
                                            input logic [7:0] wrap_v);
        logic [8:0] r;
        if (v >= max_v) r = {1'b1, wrap_v};
        else if (v[3:0] >= 4'd9) r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // 12h: 11->12 toggles PM and carries only on the PM->AM turn; 12->01 keeps PM.
    function automatic logic [8:0] hour_step(input logic [7:0] h, input logic mode12);
        logic [8:0] r;
        if (mode12) begin
            if (h[6:0] == 7'h11) r = {h[7], ~h[7], 7'h12};
            else if (h[6:0] >= 7'h12) r = {1'b0, h[7], 7'h01};
            else if (h[3:0] >= 4'd9) r = {1'b0, h[7], h[6:4] + 3'd1, 4'd0};
            else r = {1'b0, h[7], h[6:4], h[3:0] + 4'd1};
        end else begin
            r = bcd_step({2'b00, h[5:0]}, 8'h23, 8'h00);
        end
        return r;
    endfunction

`ifdef TICK_GEN_EN
    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    logic [CW-1:0] div_q, div_d;
    logic          unused_tick_s;
    assign unused_tick_s = tick_1hz;

    // Free-running divider producing one tick every CLK_HZ clocks.
    always_comb begin
        if (div_q == CW'(CLK_HZ - 1)) begin
            div_d  = '0;
            tick_s = 1'b1;
        end else begin
            div_d  = div_q + CW'(1);
            tick_s = 1'b0;
        end
    end

    // Divider register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) div_q <= '0;
        else        div_q <= div_d;
    end
`else
    logic [31:0] unused_clk_hz_s;
    assign unused_clk_hz_s = CLK_HZ;
    assign tick_s = tick_1hz;
`endif

    // Read mux over the register map.
    always_comb begin
        case (addr_q)
            8'h00:   rd_mux_s = ctrl_q;
            8'h21:   rd_mux_s = sec_q;
            8'h22:   rd_mux_s = min_q;
            8'h23:   rd_mux_s = hour_q;
            8'h24:   rd_mux_s = date_q;
            8'h25:   rd_mux_s = month_q;
            8'h26:   rd_mux_s = year_q;
            8'h27:   rd_mux_s = wday_q;
            default: rd_mux_s = IDLE_DATA;
        endcase
    end

    // Phase FSM, address latch and read drive.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ad_oe_d = 1'b0;
        adout_d = IDLE_DATA;
        case (state_q)
            S_IDLE: begin
                if (!cs_s_q) state_d = ad_s_q ? S_DATA : S_ADDR;
                else         state_d = S_IDLE;
            end
            S_ADDR, S_DATA: begin
                if (cs_s_q) state_d = S_IDLE;
                else        state_d = state_q;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q == S_ADDR && !cs_s_q && wr_rise_s) addr_d = adin_s_q;
        else                                           addr_d = addr_q;
        // The first driving cycle captures the snapshot; it is held until rd rises.
        if (state_q == S_DATA && !cs_s_q && !rd_s_q && wr_s_q) begin
            ad_oe_d = 1'b1;
            adout_d = ad_oe_q ? adout_q : rd_mux_s;
        end else begin
            ad_oe_d = 1'b0;
            adout_d = IDLE_DATA;
        end
    end

    // Timekeeping ripple with deferred tick, then the bus write overrides its target.
    always_comb begin
        wr_rise_s   = wr_s_q & ~wr_p_q;
        wr_en_s     = (state_q == S_DATA) & ~cs_s_q & wr_rise_s;
        reading_s   = (state_q == S_DATA) & ~rd_s_q;
        do_tick_s   = ~reading_s & (tick_s | pend_q);
        pend_d      = reading_s ? (pend_q | tick_s) : 1'b0;
        sec_st_s    = bcd_step(sec_q, 8'h59, 8'h00);
        min_st_s    = bcd_step(min_q, 8'h59, 8'h00);
        hour_st_s   = hour_step(hour_q, ctrl_q[4]);
        date_st_s   = bcd_step(date_q, 8'h31, 8'h01);
        month_st_s  = bcd_step(month_q, 8'h12, 8'h01);
        year_st_s   = bcd_step(year_q, 8'h99, 8'h00);
        wday_st_s   = bcd_step(wday_q, 8'h07, 8'h01);
        unused_carry_s = year_st_s[8] ^ wday_st_s[8];
        inc_min_s   = do_tick_s & sec_st_s[8];
        inc_hour_s  = inc_min_s & min_st_s[8];
        inc_date_s  = inc_hour_s & hour_st_s[8];
        inc_month_s = inc_date_s & date_st_s[8];
        inc_year_s  = inc_month_s & month_st_s[8];
        ctrl_d  = ctrl_q;
        sec_d   = do_tick_s   ? sec_st_s[7:0]   : sec_q;
        min_d   = inc_min_s   ? min_st_s[7:0]   : min_q;
        hour_d  = inc_hour_s  ? hour_st_s[7:0]  : hour_q;
        date_d  = inc_date_s  ? date_st_s[7:0]  : date_q;
        month_d = inc_month_s ? month_st_s[7:0] : month_q;
        year_d  = inc_year_s  ? year_st_s[7:0]  : year_q;
        wday_d  = inc_date_s  ? wday_st_s[7:0]  : wday_q;
        if (wr_en_s) begin
            case (addr_q)
                8'h00:   ctrl_d  = adin_s_q;
                8'h21:   sec_d   = adin_s_q;
                8'h22:   min_d   = adin_s_q;
                8'h23:   hour_d  = adin_s_q;
                8'h24:   date_d  = adin_s_q;
                8'h25:   month_d = adin_s_q;
                8'h26:   year_d  = adin_s_q;
                8'h27:   wday_d  = adin_s_q;
                default: ctrl_d  = ctrl_q;
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // Input registers and wr edge history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ad_s_q   <= 1'b1;
            cs_s_q   <= 1'b1;
            wr_s_q   <= 1'b1;
            rd_s_q   <= 1'b1;
            wr_p_q   <= 1'b1;
            adin_s_q <= 8'h00;
        end else begin
            ad_s_q   <= bus.ad;
            cs_s_q   <= bus.cs;
            wr_s_q   <= bus.wr;
            rd_s_q   <= bus.rd;
            wr_p_q   <= wr_s_q;
            adin_s_q <= bus.ADin;
        end
    end

    // FSM state, bus outputs and register file.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= 8'hFF;
            adout_q <= IDLE_DATA;
            ad_oe_q <= 1'b0;
            pend_q  <= 1'b0;
            ctrl_q  <= 8'h00;
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            hour_q  <= 8'h00;
            date_q  <= 8'h01;
            month_q <= 8'h01;
            year_q  <= 8'h00;
            wday_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            adout_q <= adout_d;
            ad_oe_q <= ad_oe_d;
            pend_q  <= pend_d;
            ctrl_q  <= ctrl_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            date_q  <= date_d;
            month_q <= month_d;
            year_q  <= year_d;
            wday_q  <= wday_d;
        end
    end

    assign bus.ADout = adout_q;
    assign bus.ad_oe = ad_oe_q;
endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
- Responder end of the multiplexed address/data RTC bus (ad, cs, wr, rd, 8-bit AD).
- Decodes address and data phases, serves a BCD timekeeping register file, and keeps time from a 1 Hz tick.
- Used as a synthesizable stand-in for the external RTC chip, for FPGA loopback and simulation against the bus master.

Parameters:
- CLK_HZ, 100000000, clock frequency; used only by the optional internal tick generator.
- IDLE_DATA, 8'hFF, value on ADout when not driving and for unmapped reads.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ADin  in  8  bus value from master (master's ADout).
- ad  in  1  address strobe; 0 = address phase, 1 = data phase.
- cs  in  1  chip select, active-low.
- wr  in  1  write strobe, active-low.
- rd  in  1  read strobe, active-low.
- tick_1hz  in  1  one-clock pulse per second; ignored when TICK_GEN_EN is defined.
- ADout  out  8  read data to master.
- ad_oe  out  1  1 while responder drives ADout.
- addr_q  out  8  last latched address (debug).

Behaviour:
- Reset (reset=0, async): ADout=IDLE_DATA, ad_oe=0, addr_q=8'hFF, state=S_IDLE.
  - Register reset values: ctrl=00, sec=00, min=00, hour=00, date=01, month=01, year=00, wday=01.
- Inputs ad, cs, wr, rd are registered once. Edges are detected on the registered copies, so latency is 2 clocks from pin change to action.
- Register map:
  - 0x00 ctrl: bit4 = 12h mode; other bits are R/W storage.
  - 0x21 sec, 0x22 min, 0x23 hour, 0x24 date, 0x25 month, 0x26 year, 0x27 wday.
  - Any other address reads IDLE_DATA; writes to it are ignored.
- FSM states:
  - S_IDLE: cs=1. Go to S_ADDR when cs=0 and ad=0; go to S_DATA when cs=0 and ad=1.
  - S_ADDR: on wr rising edge, addr_q<=ADin. Return to S_IDLE when cs=1.
  - S_DATA, write: on wr rising edge, reg[addr_q]<=ADin. ADin is sampled on the same registered edge.
  - S_DATA, read: while rd=0, ad_oe=1 and ADout=reg[addr_q], with a read snapshot taken at rd falling edge. When rd=1, ad_oe=0 and ADout=IDLE_DATA. Return to S_IDLE when cs=1.
  - Any state: cs=1 forces ad_oe=0 and a return to S_IDLE within 1 clock.
- Protocol violations:
  - wr=0 and rd=0 simultaneously: write takes priority, ad_oe stays 0.
  - ad toggling while cs=0: the phase is re-evaluated only in S_IDLE; the current phase completes.
  - rd edge in S_ADDR: ignored.
- 12h hour format (ctrl bit4=1): bits6:0 hold BCD 01..12, bit7 = PM.
  - The read of 0x23 returns the stored value unchanged.
- 24h hour format (ctrl bit4=0): bits5:0 hold BCD 00..23, bit7=0.
- Timekeeping on each tick, with BCD ripple carry:
  - sec 59 -> 00 and carries to min; min 59 -> 00 and carries to hour.
  - 24h: hour 23 -> 00 carries to date.
  - 12h: 11 AM -> 12 PM sets PM; 11 PM -> 12 AM clears PM and carries to date; 12 -> 01 keeps the PM bit.
  - date 31 -> 01 carries to month; month 12 -> 01 carries to year; year 99 -> 00.
  - wday 07 -> 01 on each date carry. There is no month-length correction.
- Tick during an active read (S_DATA with rd=0): the tick is deferred until rd rises. One deferred tick is held; further ticks during the same read are dropped.
- Tick in the same clock as a write edge: the write wins for the written register. Carries into other registers still apply.
- Illegal BCD digits written by software: increment treats any digit above 9 as a carry-out. The next tick yields a legal value.

Optional Feature:
- TICK_GEN_EN defined: an internal counter of width clog2(CLK_HZ) generates a tick pulse every CLK_HZ clocks; tick_1hz is ignored. The counter resets to 0.
- TICK_GEN_EN undefined: tick_1hz is used directly; no divider logic.

Test Plan:
- Reset mid-read (rd=0, ad_oe=1) -> ad_oe=0 and ADout=FF immediately (async); addr_q=FF; sec reads 00.
- Address cycle 0x23, then write 0x45, then address 0x23 and read -> ADout=0x45 with ad_oe=1 during rd=0; ad_oe falls 2 clocks after rd rises.
- 24h mode, hour=23, min=59, sec=59, date=31, month=12, year=99, then one tick -> 00:00:00, date 01, month 01, year 00.
- 12h mode (write ctrl=0x10), hour=0x11, min=59, sec=59, then tick -> hour=0x92 (12 PM).
  - Repeat from hour=0x91 -> hour=0x12 (12 AM) with date carry.
  - From hour=0x92 (12 PM) -> hour=0x81 (01 PM).
- Tick asserted while rd=0 on sec=0x10 -> read returns 0x10; sec becomes 0x11 after rd rises; two ticks during the read still give 0x11.
- Read of unmapped 0x55 -> ADout=FF with ad_oe=1.
  - Write 0x77 to 0x55, then read 0x21 -> sec unchanged.
